// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with r0 hardwired to zero and a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*AW-1:0]     ra,
  output logic [NREAD*WIDTH-1:0]  rd,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    wa,
  input  logic [NWRITE*WIDTH-1:0] wd,
  input  logic                    rsv,
  input  logic [AW-1:0]           rsv_addr
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  // Ascending port order lets the highest-index writer win; the reservation runs last so set beats clear.
  always_comb begin
    mem_d = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++)
      for (int r = 1; r < DEPTH; r++)
        if (we[j] && wa[j*AW +: AW] == AW'(r)) begin
          mem_d[r] = wd[j*WIDTH +: WIDTH];
          busy_d[r] = 1'b0;
        end
    for (int r = 1; r < DEPTH; r++)
      if (rsv && rsv_addr == AW'(r)) busy_d[r] = 1'b1;
    mem_d[0] = '0;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
      busy_q <= '0;
    end else begin
      mem_q <= mem_d;
      busy_q <= busy_d;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             b;
`ifdef RF_BYPASS_EN
    logic             v;
`endif
    assign a = ra[i*AW +: AW];
    always_comb begin
      d = '0;
      b = 1'b0;
      for (int r = 1; r < DEPTH; r++)
        if (a == AW'(r)) begin
          d = mem_q[r];
          b = busy_q[r];
        end
`ifdef RF_BYPASS_EN
      v = 1'b0;
      for (int r = 1; r < DEPTH; r++)
        if (a == AW'(r)) v = 1'b1;
      // Forwarding is suppressed in reset so outputs stay all-zero there.
      for (int j = 0; j < NWRITE; j++)
        if (rst_n && v && we[j] && wa[j*AW +: AW] == a) begin
          d = wd[j*WIDTH +: WIDTH];
          b = rsv && rsv_addr == a;
        end
`endif
    end
    assign rd[i*WIDTH +: WIDTH] = d;
    assign rbusy[i] = b;
  end
endmodule
